// File: rtl/store_buffer.sv
// Store buffer: holds speculative stores from MEM, commits them on ROB permission,
// drains committed stores to the D-cache in order and forwards data to younger loads.

module sb_fwd_match #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 vld,
  input  logic [WORD_SIZE-1:0] st_addr,
  input  logic                 st_byte,
  input  logic [WORD_SIZE-1:0] ld_addr,
  input  logic                 ld_byte,
  output logic                 hit
);
  assign hit = vld && (st_addr[WORD_SIZE-1:2] == ld_addr[WORD_SIZE-1:2]) &&
               (!st_byte || !ld_byte || (st_addr[1:0] == ld_addr[1:0]));
endmodule

module store_buffer #(
  parameter int N               = 4,
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_store_valid,
  input  logic [WORD_SIZE-1:0]       mem_store_addr,
  input  logic [WORD_SIZE-1:0]       mem_store_data,
  input  logic                       mem_store_byte,
  input  logic [ROB_ENTRY_WIDTH-1:0] mem_store_rob_id,
  output logic                       full,
  output logic                       empty,
  input  logic                       sb_store_permission,
  input  logic [ROB_ENTRY_WIDTH-1:0] sb_rob_id,
  input  logic                       flush,
  input  logic                       ld_valid,
  input  logic [WORD_SIZE-1:0]       ld_addr,
  input  logic                       ld_byte,
  output logic                       fwd_hit,
  output logic [WORD_SIZE-1:0]       fwd_data,
  output logic                       fwd_stall,
  output logic                       dc_wvalid,
  output logic [WORD_SIZE-1:0]       dc_waddr,
  output logic [WORD_SIZE-1:0]       dc_wdata,
  output logic                       dc_wbyte,
  input  logic                       dc_wready,
  output logic                       proto_err
);
  localparam int PW = $clog2(N);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {FREE, PENDING, COMMITTED} st_e;
  typedef struct packed {
    logic [WORD_SIZE-1:0]       addr;
    logic [WORD_SIZE-1:0]       data;
    logic                       is_byte;
    logic [ROB_ENTRY_WIDTH-1:0] rob_id;
  } ent_t;

  st_e             st [N];
  ent_t [N-1:0]    ent;
  logic [PW-1:0]   head, cmt, tail;
  logic [CW-1:0]   count, ncmt;
  logic            alloc, perm_ok, commit, pop;

  assign full      = (count == CW'(N));
  assign empty     = (count == '0);
  assign alloc     = mem_store_valid && !full && !flush;
  assign perm_ok   = sb_store_permission && (st[cmt] == PENDING) && (ent[cmt].rob_id == sb_rob_id);
  assign commit    = perm_ok && !flush;
  assign dc_wvalid = (st[head] == COMMITTED);
  assign pop       = dc_wvalid && dc_wready;

  // Pending entries always form the run [cmt, tail), so a flush just pulls tail back to cmt;
  // ncmt tracks the committed run [head, cmt) since pointers alone cannot tell 0 from N.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) st[i] <= FREE;
      head      <= '0;
      cmt       <= '0;
      tail      <= '0;
      count     <= '0;
      ncmt      <= '0;
      proto_err <= 1'b0;
    end else begin
      if (pop) begin
        st[head] <= FREE;
        head     <= head + PW'(1);
      end
      if (flush) begin
        for (int i = 0; i < N; i++) if (st[i] == PENDING) st[i] <= FREE;
        tail  <= cmt;
        count <= ncmt - CW'(pop);
        ncmt  <= ncmt - CW'(pop);
      end else begin
        if (alloc) begin
          st[tail] <= PENDING;
          tail     <= tail + PW'(1);
        end
        if (commit) begin
          st[cmt] <= COMMITTED;
          cmt     <= cmt + PW'(1);
        end
        if (sb_store_permission && !perm_ok) proto_err <= 1'b1;
        count <= count + CW'(alloc) - CW'(pop);
        ncmt  <= ncmt + CW'(commit) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      ent[tail].addr    <= mem_store_addr;
      ent[tail].data    <= mem_store_data;
      ent[tail].is_byte <= mem_store_byte;
      ent[tail].rob_id  <= mem_store_rob_id;
    end
  end

  assign dc_waddr = dc_wvalid ? ent[head].addr    : '0;
  assign dc_wdata = dc_wvalid ? ent[head].data    : '0;
  assign dc_wbyte = dc_wvalid ? ent[head].is_byte : 1'b0;

  logic [N-1:0] ov;
  for (genvar g = 0; g < N; g++) begin : g_match
    sb_fwd_match #(.WORD_SIZE(WORD_SIZE)) u_match (
      .vld     (st[g] != FREE),
      .st_addr (ent[g].addr),
      .st_byte (ent[g].is_byte),
      .ld_addr (ld_addr),
      .ld_byte (ld_byte),
      .hit     (ov[g])
    );
  end

  logic          found;
  logic [PW-1:0] yidx;
  ent_t          yent;

  // Walk entries oldest to youngest; the last overlap seen is the youngest.
  always_comb begin
    found     = 1'b0;
    yidx      = '0;
    yent      = '0;
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    for (int k = 0; k < N; k++) begin
      if (ov[head + PW'(k)]) begin
        found = 1'b1;
        yidx  = head + PW'(k);
      end
    end
    yent = ent[yidx];
    if (ld_valid && found) begin
      if (yent.is_byte && !ld_byte) begin
        fwd_stall = 1'b1;
      end else begin
        fwd_hit = 1'b1;
        if (!ld_byte)          fwd_data = yent.data;
        else if (yent.is_byte) fwd_data = {{(WORD_SIZE-8){1'b0}}, yent.data[7:0]};
        else                   fwd_data = {{(WORD_SIZE-8){1'b0}}, yent.data[8*ld_addr[1:0] +: 8]};
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized run
// against a queue-based model of the buffer.
module tb_store_buffer;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_store_valid = 1'b0;
  logic [31:0] mem_store_addr = '0;
  logic [31:0] mem_store_data = '0;
  logic        mem_store_byte = 1'b0;
  logic [3:0]  mem_store_rob_id = '0;
  logic        full, empty;
  logic        sb_store_permission = 1'b0;
  logic [3:0]  sb_rob_id = '0;
  logic        flush = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_byte = 1'b0;
  logic        fwd_hit, fwd_stall;
  logic [31:0] fwd_data;
  logic        dc_wvalid;
  logic [31:0] dc_waddr, dc_wdata;
  logic        dc_wbyte;
  logic        dc_wready = 1'b0;
  logic        proto_err;

  int n_cmp = 0;
  int n_err = 0;

  store_buffer #(.N(N), .WORD_SIZE(32), .ROB_ENTRY_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .mem_store_valid(mem_store_valid), .mem_store_addr(mem_store_addr),
    .mem_store_data(mem_store_data), .mem_store_byte(mem_store_byte),
    .mem_store_rob_id(mem_store_rob_id), .full(full), .empty(empty),
    .sb_store_permission(sb_store_permission), .sb_rob_id(sb_rob_id), .flush(flush),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_byte(ld_byte),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .dc_wvalid(dc_wvalid), .dc_waddr(dc_waddr), .dc_wdata(dc_wdata), .dc_wbyte(dc_wbyte),
    .dc_wready(dc_wready), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    mem_store_valid = 0; mem_store_byte = 0; sb_store_permission = 0;
    flush = 0; ld_valid = 0; ld_byte = 0; dc_wready = 0;
  endtask

  task automatic alloc(input logic [31:0] a, input logic [31:0] d, input logic b, input logic [3:0] r);
    mem_store_valid = 1; mem_store_addr = a; mem_store_data = d; mem_store_byte = b; mem_store_rob_id = r;
    tick();
    mem_store_valid = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    #1;
    n_cmp++; if ({full, empty, dc_wvalid, dc_wbyte, proto_err, fwd_hit, fwd_stall} !== 7'b0100000) begin n_err++; $display("FAIL reset_flags got=%b exp=0100000", {full, empty, dc_wvalid, dc_wbyte, proto_err, fwd_hit, fwd_stall}); end
    n_cmp++; if ({dc_waddr, dc_wdata, fwd_data} !== 96'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", {dc_waddr, dc_wdata, fwd_data}); end
    #12 rst = 1;
    tick();
  endtask

  task automatic test_basic();
    alloc(32'h100, 32'hDEADBEEF, 0, 4'd3);
    #1;
    n_cmp++; if ({empty, dc_wvalid} !== 2'b00) begin n_err++; $display("FAIL basic_alloc got=%b exp=00", {empty, dc_wvalid}); end
    sb_store_permission = 1; sb_rob_id = 4'd3; dc_wready = 1;
    tick();
    sb_store_permission = 0;
    #1;
    n_cmp++; if ({dc_wvalid, dc_waddr, dc_wdata, dc_wbyte} !== {1'b1, 32'h100, 32'hDEADBEEF, 1'b0}) begin n_err++; $display("FAIL basic_drain got=%b %h %h exp=1 100 deadbeef", dc_wvalid, dc_waddr, dc_wdata); end
    tick();
    dc_wready = 0;
    #1;
    n_cmp++; if ({empty, dc_wvalid, proto_err} !== 3'b100) begin n_err++; $display("FAIL basic_empty got=%b exp=100", {empty, dc_wvalid, proto_err}); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < N; i++) alloc(32'h300 + 32'(4*i), 32'hA0 + 32'(i), 0, 4'(i));
    mem_store_valid = 1; mem_store_addr = 32'h310; mem_store_data = 32'hBAD; mem_store_rob_id = 4'd4;
    #1;
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got=%b exp=1", full); end
    tick();
    mem_store_valid = 0;
    for (int i = 0; i < N; i++) begin
      sb_store_permission = 1; sb_rob_id = 4'(i);
      tick();
      #1;
      n_cmp++; if ({dc_wvalid, dc_waddr, dc_wdata} !== {1'b1, 32'h300, 32'hA0}) begin n_err++; $display("FAIL fill_stable%0d got=%b %h %h exp=1 300 a0", i, dc_wvalid, dc_waddr, dc_wdata); end
    end
    sb_store_permission = 0; dc_wready = 1;
    for (int i = 0; i < N; i++) begin
      #1;
      n_cmp++; if ({dc_wvalid, dc_waddr, dc_wdata} !== {1'b1, 32'h300 + 32'(4*i), 32'hA0 + 32'(i)}) begin n_err++; $display("FAIL fill_order%0d got=%b %h %h", i, dc_wvalid, dc_waddr, dc_wdata); end
      tick();
    end
    dc_wready = 0;
    #1;
    n_cmp++; if ({empty, dc_wvalid, proto_err} !== 3'b100) begin n_err++; $display("FAIL fill_drained got=%b exp=100", {empty, dc_wvalid, proto_err}); end
    alloc(32'h340, 32'h5555AAAA, 0, 4'd7);
    ld_valid = 1; ld_addr = 32'h340; ld_byte = 0;
    #1;
    n_cmp++; if ({fwd_hit, fwd_stall, fwd_data} !== {2'b10, 32'h5555AAAA}) begin n_err++; $display("FAIL wrap_fwd got=%b%b %h exp=10 5555aaaa", fwd_hit, fwd_stall, fwd_data); end
    ld_valid = 0; flush = 1;
    tick();
    flush = 0;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_flush got=%b exp=1", empty); end
  endtask

  task automatic test_forward();
    alloc(32'h200, 32'h11223344, 0, 4'd1);
    ld_valid = 1; ld_addr = 32'h202; ld_byte = 1;
    #1;
    n_cmp++; if ({fwd_hit, fwd_stall, fwd_data} !== {2'b10, 32'h22}) begin n_err++; $display("FAIL fwd_byte_of_word got=%b%b %h exp=10 22", fwd_hit, fwd_stall, fwd_data); end
    // the store being allocated this cycle is not yet visible to the load
    mem_store_valid = 1; mem_store_addr = 32'h201; mem_store_data = 32'hFFFFFFAA; mem_store_byte = 1; mem_store_rob_id = 4'd2;
    ld_addr = 32'h200; ld_byte = 0;
    #1;
    n_cmp++; if ({fwd_hit, fwd_stall, fwd_data} !== {2'b10, 32'h11223344}) begin n_err++; $display("FAIL fwd_same_cycle got=%b%b %h exp=10 11223344", fwd_hit, fwd_stall, fwd_data); end
    tick();
    mem_store_valid = 0; mem_store_byte = 0;
    #1;
    n_cmp++; if ({fwd_hit, fwd_stall} !== 2'b01) begin n_err++; $display("FAIL fwd_stall got=%b%b exp=01", fwd_hit, fwd_stall); end
    ld_addr = 32'h201; ld_byte = 1;
    #1;
    n_cmp++; if ({fwd_hit, fwd_stall, fwd_data} !== {2'b10, 32'hAA}) begin n_err++; $display("FAIL fwd_byte_byte got=%b%b %h exp=10 aa", fwd_hit, fwd_stall, fwd_data); end
    ld_addr = 32'h203;
    #1;
    n_cmp++; if ({fwd_hit, fwd_stall, fwd_data} !== {2'b10, 32'h11}) begin n_err++; $display("FAIL fwd_other_byte got=%b%b %h exp=10 11", fwd_hit, fwd_stall, fwd_data); end
    ld_addr = 32'h204; ld_byte = 0;
    #1;
    n_cmp++; if ({fwd_hit, fwd_stall, fwd_data} !== {2'b00, 32'h0}) begin n_err++; $display("FAIL fwd_miss got=%b%b %h exp=00 0", fwd_hit, fwd_stall, fwd_data); end
    ld_valid = 0; flush = 1;
    tick();
    flush = 0;
    #1;
    n_cmp++; if ({empty, proto_err} !== 2'b10) begin n_err++; $display("FAIL fwd_flush got=%b exp=10", {empty, proto_err}); end
  endtask

  task automatic test_flush();
    alloc(32'h400, 32'h1234, 0, 4'd1);
    alloc(32'h404, 32'h5678, 0, 4'd2);
    sb_store_permission = 1; sb_rob_id = 4'd1;
    tick();
    flush = 1; sb_rob_id = 4'd2;
    tick();
    flush = 0; sb_store_permission = 0;
    #1;
    n_cmp++; if ({dc_wvalid, dc_waddr, dc_wdata, proto_err} !== {1'b1, 32'h400, 32'h1234, 1'b0}) begin n_err++; $display("FAIL flush_keep got=%b %h %h %b", dc_wvalid, dc_waddr, dc_wdata, proto_err); end
    dc_wready = 1;
    tick();
    dc_wready = 0;
    #1;
    n_cmp++; if ({empty, dc_wvalid, proto_err} !== 3'b100) begin n_err++; $display("FAIL flush_discard got=%b exp=100", {empty, dc_wvalid, proto_err}); end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        b;
    logic [3:0]  rob;
    bit          c;
  } me_t;

  task automatic test_random();
    me_t q[$];
    me_t nq[$];
    bit m_perr = 0;
    logic [3:0] next_rob = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic e_hit, e_stall, e_wv;
      logic [31:0] e_data, lane;
      int pidx;
      bit s_val, s_perm, s_flush, s_rdy, pre_full, do_pop;
      me_t ne;
      mem_store_valid = ($urandom % 2) == 1;
      mem_store_byte  = ($urandom % 2) == 1;
      mem_store_addr  = 32'h500 + 32'(4 * $urandom_range(0, 1)) + (mem_store_byte ? 32'($urandom_range(0, 3)) : 32'h0);
      mem_store_data  = $urandom;
      mem_store_rob_id = next_rob;
      pidx = -1;
      for (int j = 0; j < q.size(); j++) if (!q[j].c) begin pidx = j; break; end
      sb_store_permission = ($urandom % 3) == 0;
      sb_rob_id = (pidx >= 0 && ($urandom % 4) != 0) ? q[pidx].rob : 4'($urandom_range(0, 15));
      flush     = ($urandom % 20) == 0;
      dc_wready = ($urandom % 2) == 1;
      ld_valid  = ($urandom % 2) == 1;
      ld_byte   = ($urandom % 2) == 1;
      ld_addr   = 32'h500 + 32'(4 * $urandom_range(0, 1)) + (ld_byte ? 32'($urandom_range(0, 3)) : 32'h0);
      #1;
      e_hit = 0; e_stall = 0; e_data = 0;
      if (ld_valid) begin
        for (int j = q.size() - 1; j >= 0; j--) begin
          if (q[j].addr[31:2] == ld_addr[31:2] && (!q[j].b || !ld_byte || q[j].addr[1:0] == ld_addr[1:0])) begin
            lane = q[j].b ? ((q[j].data & 32'hFF) << (8 * q[j].addr[1:0])) : q[j].data;
            if (q[j].b && !ld_byte) e_stall = 1;
            else begin
              e_hit = 1;
              e_data = ld_byte ? ((lane >> (8 * ld_addr[1:0])) & 32'hFF) : lane;
            end
            break;
          end
        end
      end
      e_wv = q.size() > 0 && q[0].c;
      n_cmp++; if ({full, empty, dc_wvalid, proto_err} !== {q.size() == N, q.size() == 0, e_wv, m_perr}) begin n_err++; $display("FAIL rnd_status cyc=%0d got=%b exp=%b", cyc, {full, empty, dc_wvalid, proto_err}, {q.size() == N, q.size() == 0, e_wv, m_perr}); end
      n_cmp++; if ({fwd_hit, fwd_stall, fwd_data} !== {e_hit, e_stall, e_data}) begin n_err++; $display("FAIL rnd_fwd cyc=%0d got=%b%b %h exp=%b%b %h", cyc, fwd_hit, fwd_stall, fwd_data, e_hit, e_stall, e_data); end
      if (e_wv) begin
        n_cmp++;
        if (dc_waddr !== q[0].addr || dc_wbyte !== q[0].b || (q[0].b ? (dc_wdata[7:0] !== q[0].data[7:0]) : (dc_wdata !== q[0].data))) begin
          n_err++; $display("FAIL rnd_dc cyc=%0d got=%h %h %b exp=%h %h %b", cyc, dc_waddr, dc_wdata, dc_wbyte, q[0].addr, q[0].data, q[0].b);
        end
      end
      s_val = mem_store_valid; s_perm = sb_store_permission; s_flush = flush; s_rdy = dc_wready;
      ne = '{addr: mem_store_addr, data: mem_store_data, b: mem_store_byte, rob: mem_store_rob_id, c: 0};
      pre_full = q.size() == N;
      do_pop = e_wv && s_rdy;
      if (s_flush) begin
        nq = {};
        foreach (q[j]) if (q[j].c) nq.push_back(q[j]);
        q = nq;
      end else if (s_perm) begin
        if (pidx >= 0 && q[pidx].rob == sb_rob_id) q[pidx].c = 1;
        else m_perr = 1;
      end
      if (do_pop) void'(q.pop_front());
      if (!s_flush && s_val && !pre_full) begin
        q.push_back(ne);
        next_rob++;
      end
      tick();
    end
    idle();
    flush = 1;
    tick();
    flush = 0; dc_wready = 1;
    repeat (N) tick();
    idle();
    #1;
    n_cmp++; if ({empty, dc_wvalid} !== 2'b10) begin n_err++; $display("FAIL rnd_final got=%b exp=10", {empty, dc_wvalid}); end
    rst = 0;
    #2 rst = 1;
    tick();
  endtask

  task automatic test_proto();
    alloc(32'h700, 32'h77, 0, 4'd4);
    sb_store_permission = 1; sb_rob_id = 4'd5;
    tick();
    #1;
    n_cmp++; if ({proto_err, dc_wvalid} !== 2'b10) begin n_err++; $display("FAIL proto_set got=%b exp=10", {proto_err, dc_wvalid}); end
    sb_rob_id = 4'd4;
    tick();
    sb_store_permission = 0; dc_wready = 1;
    #1;
    n_cmp++; if ({proto_err, dc_wvalid, dc_waddr} !== {2'b11, 32'h700}) begin n_err++; $display("FAIL proto_commit got=%b %b %h", proto_err, dc_wvalid, dc_waddr); end
    tick();
    dc_wready = 0;
    #1;
    n_cmp++; if ({proto_err, empty} !== 2'b11) begin n_err++; $display("FAIL proto_sticky got=%b exp=11", {proto_err, empty}); end
  endtask

  task automatic test_reset_mid_drain();
    alloc(32'h600, 32'hCAFEF00D, 0, 4'd9);
    sb_store_permission = 1; sb_rob_id = 4'd9;
    tick();
    sb_store_permission = 0;
    #1;
    n_cmp++; if (dc_wvalid !== 1'b1) begin n_err++; $display("FAIL midrst_pre got=%b exp=1", dc_wvalid); end
    #1 rst = 0;
    #1;
    n_cmp++; if ({full, empty, dc_wvalid, dc_wbyte, proto_err, fwd_hit, fwd_stall} !== 7'b0100000) begin n_err++; $display("FAIL midrst_flags got=%b exp=0100000", {full, empty, dc_wvalid, dc_wbyte, proto_err, fwd_hit, fwd_stall}); end
    n_cmp++; if ({dc_waddr, dc_wdata, fwd_data} !== 96'h0) begin n_err++; $display("FAIL midrst_data got=%h exp=0", {dc_waddr, dc_wdata, fwd_data}); end
    tick();
    rst = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_wrap();
    test_forward();
    test_flush();
    test_random();
    test_proto();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Holds committed-in-order stores between the MEM stage and the D-cache write port. It is the consumer of the ROB's store-permission interface (`sb_store_permission`, `sb_rob_id`). Stores are allocated speculatively from MEM and marked committed when the ROB grants permission. Committed stores drain to the D-cache in program order. The block also forwards data to younger loads and discards uncommitted stores on an exception flush.

## Interface
- `N`, default `SB_NUM_ENTRIES` (4): entry count; must be a power of 2, at least 2.
- `WORD_SIZE`, default `WORD_SIZE` (32): address and data width.
- `ROB_ENTRY_WIDTH`, default `ROB_ENTRY_WIDTH`: ROB id width.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_store_valid` in 1: allocate a store this cycle.
- `mem_store_addr` in WORD_SIZE: byte address.
- `mem_store_data` in WORD_SIZE: store data; a byte store uses bits [7:0].
- `mem_store_byte` in 1: 1 = byte store, 0 = word store.
- `mem_store_rob_id` in ROB_ENTRY_WIDTH: ROB id of the store.
- `full` out 1: count == N. MEM must stall while high.
- `empty` out 1: count == 0.
- `sb_store_permission` in 1: ROB head is a ready store.
- `sb_rob_id` in ROB_ENTRY_WIDTH: ROB id of that head store.
- `flush` in 1: ROB exception; drop all uncommitted entries.
- `ld_valid` in 1: load lookup request.
- `ld_addr` in WORD_SIZE: load byte address.
- `ld_byte` in 1: 1 = byte load, 0 = word load.
- `fwd_hit` out 1: load fully covered; data valid on `fwd_data`.
- `fwd_data` out WORD_SIZE: forwarded data. For a byte load: the byte, zero-extended.
- `fwd_stall` out 1: partial overlap; the load must retry.
- `dc_wvalid` out 1: D-cache write request.
- `dc_waddr` out WORD_SIZE: write address.
- `dc_wdata` out WORD_SIZE: write data.
- `dc_wbyte` out 1: write size.
- `dc_wready` in 1: D-cache accepts the write this cycle.
- `proto_err` out 1: sticky; a permission id mismatch occurred.

## Operation
- Circular FIFO with pointers `head` (oldest), `cmt` (oldest PENDING entry) and `tail`, plus a `count`. Pointers wrap modulo N.
- Each entry holds addr, data, byte, rob_id and a state: FREE, PENDING or COMMITTED.
- Allocate: if `mem_store_valid && !full`, write the entry at `tail` with state PENDING, then advance `tail` and increment `count`. If `full`, the request is ignored, even if a pop happens in the same cycle.
- Permission: if `sb_store_permission` is high and the entry at `cmt` is PENDING with `rob_id == sb_rob_id`, set it to COMMITTED and advance `cmt`.
  - Otherwise (id mismatch, no PENDING entry, or match only against an entry being allocated this cycle): ignore the permission and set `proto_err`.
  - Permission is evaluated against pre-edge state.
- Drain: `dc_wvalid` = entry at `head` is COMMITTED. `dc_w*` fields show the head entry combinationally.
  - On `dc_wvalid && dc_wready`: set the head entry to FREE, advance `head`, decrement `count`.
- Flush: every PENDING entry becomes FREE, and `tail` and `count` are set so that COMMITTED entries remain.
  - `flush` has priority over a same-cycle allocate and permission; both are ignored.
  - A same-cycle drain pop still occurs.
- `count` and allocate/pop: a same-cycle allocate and pop leaves `count` unchanged.
- Forwarding (combinational, valid only when `ld_valid`):
  - Find the youngest valid entry (PENDING or COMMITTED) that overlaps the load. Overlap requires the same word address (addr[WS-1:2]), and then either side is a word access, or both are byte accesses with equal addr[1:0].
  - Hit when the youngest overlapping entry is a word store, or is a byte store and the load is a byte load.
    - For a byte load from a word store, `fwd_data` = the byte selected by `ld_addr[1:0]`, zero-extended.
  - Stall when the youngest overlapping entry is a byte store and the load is a word load.
  - No overlap: `fwd_hit` = `fwd_stall` = 0.
  - `fwd_hit` and `fwd_stall` are never both high.
- Reset (`rst` low, asynchronous): all entries FREE; pointers and count 0; `proto_err` 0.

## Timing
- Reset values of outputs: `full` 0, `empty` 1, `dc_wvalid` 0, `dc_waddr`/`dc_wdata`/`dc_wbyte` 0, `fwd_hit` 0, `fwd_stall` 0, `fwd_data` 0, `proto_err` 0.
- An allocation at edge E0 is visible to forwarding and permission from the cycle after E0. A load in the same cycle as the allocation does not see it.
- Permission sampled at edge E1 → `dc_wvalid` high in the cycle after E1. The pop occurs at the first following edge with `dc_wready` high.
- Minimum allocate-to-cache-accept latency: 2 cycles.
- `dc_w*` must stay stable while `dc_wvalid && !dc_wready`.
- Reset asserted mid-drain drops `dc_wvalid` immediately, asynchronously.

## Test plan
- Reset, then allocate word store addr 0x100, data 0xDEADBEEF, rob 3. Next cycle permission rob 3 with `dc_wready`=1 → `dc_wvalid` one cycle later with addr 0x100, data 0xDEADBEEF; `empty`=1 after the pop.
- Fill 4 stores (rob 0..3) → `full`=1 and a 5th allocate is ignored. Grant 0..3 with `dc_wready`=0 for 3 cycles → `dc_w*` stable. Then drain in order 0..3 with pointer wrap; allocate again → entry lands at index 0.
- Word store 0x200 = 0x11223344, then byte load 0x202 → `fwd_hit`=1, `fwd_data`=0x22. Byte store 0x201 = 0xAA, then word load 0x200 → `fwd_stall`=1. Byte load 0x201 → `fwd_hit`, `fwd_data`=0xAA.
- Allocate rob 1 and rob 2; permission rob 1; `flush` together with permission rob 2 → rob 1 still drains, rob 2 is discarded, `count`=0 after the drain, `proto_err`=0.
- Permission with rob 5 while the oldest PENDING entry is rob 4 → no commit, `proto_err`=1 and stays set until reset.
- Assert `rst` low mid-drain → all outputs at reset values before the next edge.
